cnn_layer_sequencer: RTL
========================

Name: cnn_layer_sequencer

Overview:
Controller that sits between the host bus and the CNN memory and layer datapath.
- Counts host byte writes into each memory region (input image, layer 1-4 weights) and generates the per-region write address.
- Once every region is full, starts layers 1-4 in order, waiting for each done, and pulses a buffer swap between layers.
- Exposes a status byte and a control register to the host.

Parameters:
INPUT_SIZE, 10000, bytes in input image region
L1_SIZE, 400, bytes of layer 1 conv weights
L2_SIZE, 12800, bytes of layer 2 conv weights
L3_SIZE, 230400, bytes of layer 3 fc weights
L4_SIZE, 10600, bytes of layer 4 fc weights
CNT_W, 18, write counter/address width; must hold max size
TIMEOUT, 1048576, max cycles allowed per layer before error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
chipselect  in  1  host bus select
write  in  1  host write strobe
read  in  1  host read strobe
address  in  3  0-4 = region select, 5 = control/status
writedata  in  8  host write byte
readdata  out  8  status byte, registered
mem_we  out  5  one-hot region write enable, bit n = region n
mem_waddr  out  CNT_W  byte address within selected region
mem_wdata  out  8  registered copy of writedata
layer_start  out  4  one-cycle start pulse, bit k = layer k+1
layer_done  in  4  one-cycle done pulse from layer k+1
buf_swap  out  1  one-cycle pulse: swap input/output activation buffers
busy  out  1  high while any layer is running
result_ready  out  1  high after layer 4 completes, until cleared

Behaviour:
Reset:
- Asynchronous reset puts every output at 0, all counters at 0 and the state at LOAD.
- Reset mid-operation aborts the current layer with no further start or swap pulses.

Region writes (host):
- A write to region r (address 0-4) is accepted only in state LOAD and only when cnt[r] < SIZE[r].
- An accepted write gives: next cycle mem_we = 1<<r, mem_waddr = cnt[r], mem_wdata = writedata; cnt[r] increments.
- loaded[r] = (cnt[r] == SIZE[r]).
- A write to a full region, or any region write outside LOAD, is dropped with mem_we = 0 and sets the sticky err_ovf bit.
- Address 6-7 writes are ignored.

Control writes (address 5):
- writedata[0] = soft clear: all five counters -> 0, flags clear, state -> LOAD.
- writedata[1] = rerun: only the input counter -> 0, weights stay loaded, result_ready and flags clear, state -> LOAD.
- If both bits are set, bit0 wins.
- In any state a control write takes priority over layer_done in the same cycle.

Reads:
- A read to address 5 gives readdata one cycle later = {err, result_ready, busy, loaded[4:0]}, where err = err_ovf | err_seq | err_tmo.
- A read to any other address gives readdata = 0; output activations are read elsewhere.
- readdata holds its value until the next read.

State machine (state register, k = 0..3):
- LOAD: when all five loaded bits are 1 -> START(0).
- START(k): pulse layer_start[k] for exactly one cycle; clear the watchdog; -> RUN(k). busy = 1.
- RUN(k): busy = 1; the watchdog increments every cycle.
  - layer_done[k] with k < 3 -> SWAP(k).
  - layer_done[3] in RUN(3) -> DONE.
  - Any layer_done[j] with j != k -> ERR with err_seq = 1; if done[k] arrives in the same cycle, the error still wins.
  - Watchdog reaching TIMEOUT-1 without done -> ERR with err_tmo = 1.
- SWAP(k): buf_swap = 1 for one cycle -> START(k+1).
  - Latency from layer_done[k] to layer_start[k+1] is exactly 2 cycles.
- DONE: result_ready = 1, busy = 0; stays until a control write.
- ERR: busy = 0, no pulses; stays until a control write.
- layer_done pulses in LOAD, DONE or ERR are ignored.

Arithmetic:
- Counters saturate at SIZE and never wrap.
- The watchdog is clog2(TIMEOUT) bits wide and does not wrap.

Test Plan:
1. Reset mid-RUN(1) -> all outputs read 0 in the same cycle; after release state is LOAD and a status read returns 8'h00.
2. Small sizes (INPUT 4, L1-L4 2 each): write all regions -> mem_we/mem_waddr follow 0,1,2,3 per region; layer_start[0] pulses 1 cycle after the last write is registered; status reads 8'h3F while running.
3. Respond to each layer_start with layer_done 5 cycles later -> layer_start 1-3 each appear 2 cycles after the previous done, with buf_swap between them; result_ready = 1 after done[3]; status reads 8'h5F.
4. A 5th write to the full input region, plus a region write during RUN -> mem_we stays 0, counters unchanged, status bit7 = 1.
5. layer_done[2] while in RUN(0) -> ERR, busy = 0, bit7 = 1; then a control write of 8'h02 -> only loaded[0] clears (status 8'h1E); refilling the input re-runs layers 1-4.
6. With TIMEOUT = 16 and no done -> ERR on the 16th RUN cycle; a control write of 8'h03 -> full clear, status 8'h00.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Host-facing sequencer for a 4-layer CNN: counts byte writes into five memory
// regions, then starts layers 1-4 in order with buffer swaps and a per-layer watchdog.
module cnn_layer_sequencer #(
    parameter int INPUT_SIZE = 10000,
    parameter int L1_SIZE    = 400,
    parameter int L2_SIZE    = 12800,
    parameter int L3_SIZE    = 230400,
    parameter int L4_SIZE    = 10600,
    parameter int CNT_W      = 18,
    parameter int TIMEOUT    = 1048576
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             write,
    input  logic             read,
    input  logic [2:0]       address,
    input  logic [7:0]       writedata,
    output logic [7:0]       readdata,
    output logic [4:0]       mem_we,
    output logic [CNT_W-1:0] mem_waddr,
    output logic [7:0]       mem_wdata,
    output logic [3:0]       layer_start,
    input  logic [3:0]       layer_done,
    output logic             buf_swap,
    output logic             busy,
    output logic             result_ready
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_LOAD, S_START, S_RUN, S_SWAP, S_DONE, S_ERR} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       layer_reg, layer_next;
    logic [WD_W-1:0]  wd_reg, wd_next;
    logic             err_seq_reg, err_seq_next;
    logic             err_tmo_reg, err_tmo_next;
    logic             err_ovf_reg;
    logic [CNT_W-1:0] cnt_reg [5];
    logic [4:0]       loaded;
    logic [4:0]       accept;
    logic [CNT_W-1:0] waddr_sel;
    logic [3:0]       wrong_done;
    logic             host_wr, ctrl_wr, soft_clr, rerun, region_wr, drop;
    logic [7:0]       status;

    assign host_wr   = chipselect & write;
    assign ctrl_wr   = host_wr && (address == 3'd5);
    assign soft_clr  = ctrl_wr & writedata[0];
    assign rerun     = ctrl_wr & writedata[1] & ~writedata[0];
    assign region_wr = host_wr && (address < 3'd5);
    assign drop      = region_wr && (accept == 5'd0);

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_region
            localparam logic [CNT_W-1:0] SIZE = CNT_W'(gi == 0 ? INPUT_SIZE :
                                                      gi == 1 ? L1_SIZE :
                                                      gi == 2 ? L2_SIZE :
                                                      gi == 3 ? L3_SIZE : L4_SIZE);
            assign loaded[gi] = (cnt_reg[gi] == SIZE);
            // Accepting only below SIZE is what makes the counter saturate.
            assign accept[gi] = host_wr && (address == 3'(gi)) &&
                                (state_reg == S_LOAD) && !loaded[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt_reg[gi] <= '0;
                else if (soft_clr || (rerun && gi == 0))
                    cnt_reg[gi] <= '0;
                else if (accept[gi])
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    always_comb begin
        waddr_sel = '0;
        for (int i = 0; i < 5; i++)
            if (accept[i]) waddr_sel = cnt_reg[i];
    end

    assign status = {err_ovf_reg | err_seq_reg | err_tmo_reg, result_ready, busy, loaded};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we      <= '0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            err_ovf_reg <= 1'b0;
            readdata    <= '0;
        end else begin
            mem_we <= accept;
            if (|accept) begin
                mem_waddr <= waddr_sel;
                mem_wdata <= writedata;
            end
            if (soft_clr || rerun)
                err_ovf_reg <= 1'b0;
            else if (drop)
                err_ovf_reg <= 1'b1;
            if (chipselect && read)
                readdata <= (address == 3'd5) ? status : 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_LOAD;
            layer_reg   <= '0;
            wd_reg      <= '0;
            err_seq_reg <= 1'b0;
            err_tmo_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            layer_reg   <= layer_next;
            wd_reg      <= wd_next;
            err_seq_reg <= err_seq_next;
            err_tmo_reg <= err_tmo_next;
        end
    end

    assign wrong_done = layer_done & ~(4'd1 << layer_reg);

    always_comb begin
        state_next   = state_reg;
        layer_next   = layer_reg;
        wd_next      = wd_reg;
        err_seq_next = err_seq_reg;
        err_tmo_next = err_tmo_reg;
        // A host control write overrides whatever the sequence is doing.
        if (soft_clr || rerun) begin
            state_next   = S_LOAD;
            layer_next   = '0;
            wd_next      = '0;
            err_seq_next = 1'b0;
            err_tmo_next = 1'b0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    if (&loaded) begin
                        state_next = S_START;
                        layer_next = '0;
                    end
                end
                S_START: begin
                    wd_next    = '0;
                    state_next = S_RUN;
                end
                S_RUN: begin
                    if (|wrong_done) begin
                        state_next   = S_ERR;
                        err_seq_next = 1'b1;
                    end else if (layer_done[layer_reg]) begin
                        state_next = (layer_reg == 2'd3) ? S_DONE : S_SWAP;
                    end else if (wd_reg == WD_MAX) begin
                        state_next   = S_ERR;
                        err_tmo_next = 1'b1;
                    end else begin
                        wd_next = wd_reg + 1'b1;
                    end
                end
                S_SWAP: begin
                    layer_next = layer_reg + 2'd1;
                    state_next = S_START;
                end
                S_DONE, S_ERR: ;
                default: state_next = S_LOAD;
            endcase
        end
    end

    assign layer_start  = (state_reg == S_START) ? (4'd1 << layer_reg) : 4'd0;
    assign buf_swap     = (state_reg == S_SWAP);
    assign busy         = (state_reg == S_START) || (state_reg == S_RUN) || (state_reg == S_SWAP);
    assign result_ready = (state_reg == S_DONE);

endmodule
